// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between execute and a single-port word-wide data RAM.
// Sub-word stores run as read-modify-write; load results go out on the register write port.
module lsu_mem_ctrl #(
    parameter int unsigned MEM_AW = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              flush,
    input  logic [3:0]        mem_op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [4:0]        rd,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              write_req,
    output logic [4:0]        write_addr,
    output logic [31:0]       write_data,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int unsigned BYTE_AW = MEM_AW + 2;

    typedef enum logic [2:0] {IDLE, RD, RDDATA, WR, RESP} state_t;

    state_t      state;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_q;
    logic [15:0] wdata_q;
    logic [4:0]  rd_q;

    logic        accept_c;
    logic [1:0]  check_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] load_c;
    logic [31:0] merge_c;

    assign accept_c = req_valid && req_ready && !flush;

    // Request checks in priority order: illegal op, misaligned, out of range
    always_comb begin
        check_c = 2'b00;
        if (mem_op[3] ? (mem_op[2] || mem_op[1:0] == 2'b11)
                      : (mem_op[1:0] == 2'b11 || mem_op[2:1] == 2'b11))
            check_c = 2'b11;
        else if ((mem_op[1:0] == 2'b01 && addr[0]) ||
                 (mem_op[1:0] == 2'b10 && addr[1:0] != 2'b00))
            check_c = 2'b01;
        else if ((addr >> BYTE_AW) != 32'd0)
            check_c = 2'b10;
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        byte_c  = 8'(mem_rdata >> {addr_q, 3'b000});
        half_c  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_c  = mem_rdata;
        merge_c = mem_rdata;
        case (funct3_q)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  load_c = {24'd0, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b101:  load_c = {16'd0, half_c};
            default: load_c = mem_rdata;
        endcase
        if (funct3_q[0]) begin
            if (addr_q[1])
                merge_c[31:16] = wdata_q;
            else
                merge_c[15:0] = wdata_q;
        end else begin
            merge_c[{addr_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            write_req  <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
        end else begin
            write_req <= 1'b0;
            fault     <= 1'b0;
            case (state)
                // RESP doubles as an accept slot so loads sustain one per 3 cycles
                IDLE, RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    if (accept_c) begin
                        is_store_q <= mem_op[3];
                        funct3_q   <= mem_op[2:0];
                        addr_q     <= addr[1:0];
                        wdata_q    <= wdata[15:0];
                        rd_q       <= rd;
                        if (check_c != 2'b00) begin
                            fault      <= 1'b1;
                            fault_code <= check_c;
                        end else begin
                            req_ready <= 1'b0;
                            mem_en    <= 1'b1;
                            mem_addr  <= addr[BYTE_AW-1:2];
                            if (mem_op[3] && mem_op[1:0] == 2'b10) begin
                                state     <= WR;
                                mem_we    <= 1'b1;
                                mem_wdata <= wdata;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    mem_en <= 1'b0;
                    state  <= RDDATA;
                end
                RDDATA: begin
                    if (is_store_q) begin
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= merge_c;
                        state     <= WR;
                    end else begin
                        write_req  <= (rd_q != 5'd0);
                        write_addr <= rd_q;
                        write_data <= load_c;
                        req_ready  <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized requests
// compared against an arithmetic load/store model and a shadow memory.
module tb_lsu_mem_ctrl;

    localparam int unsigned MEM_AW = 7;
    localparam int unsigned DEPTH  = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              flush;
    logic [3:0]        mem_op;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [4:0]        rd;
    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              write_req;
    logic [4:0]        write_addr;
    logic [31:0]       write_data;
    logic              fault;
    logic [1:0]        fault_code;

    lsu_mem_ctrl #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .flush(flush), .mem_op(mem_op), .addr(addr), .wdata(wdata), .rd(rd),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .write_req(write_req), .write_addr(write_addr),
        .write_data(write_data), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with a backdoor write port for preloading
    logic [31:0]       ram [DEPTH];
    logic [31:0]       ref_mem [DEPTH];
    logic              bd_we = 1'b0;
    logic [MEM_AW-1:0] bd_addr;
    logic [31:0]       bd_data;
    int unsigned       wr_strobes = 0;

    always @(posedge clk) begin
        if (bd_we)
            ram[bd_addr] <= bd_data;
        else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_strobes    <= wr_strobes + 1;
        end
        if (mem_en && !mem_we)
            mem_rdata <= ram[mem_addr];
    end

    int errors = 0;
    int checks = 0;

    int                rd_cyc, wr_cyc, rd_cnt, wr_cnt, wreq_cnt, wreq_cyc, fault_cyc, ready_cyc;
    logic [4:0]        wreq_addr;
    logic [31:0]       wreq_data, wr_word;
    logic [MEM_AW-1:0] rd_addr_seen, wr_addr_seen;
    logic [1:0]        fcode_seen;

    function automatic int unsigned op_size(input logic [3:0] op);
        return 1 << (int'(op[2:0]) % 4);
    endfunction

    function automatic logic [1:0] model_code(input logic [3:0] op, input logic [31:0] a);
        int  f     = int'(op[2:0]);
        bit  legal = op[3] ? (f <= 2) : (f <= 2 || f == 4 || f == 5);
        if (!legal) return 2'd3;
        if (a % op_size(op) != 0) return 2'd1;
        if (a >= DEPTH * 4) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [3:0] op,
                                               input logic [31:0] a);
        int unsigned     size = op_size(op);
        longint unsigned w    = longint'(word);
        longint unsigned v;
        if (size == 4) return word;
        v = (w >> (8 * (a % 4))) & ((64'd1 << (8 * size)) - 1);
        if (op[2] == 1'b0 && v >= (64'd1 << (8 * size - 1)))
            v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * size));
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [3:0] op,
                                                input logic [31:0] a, input logic [31:0] wd);
        int unsigned     size = op_size(op);
        int unsigned     sh   = 8 * (a % 4);
        longint unsigned mask;
        if (size == 4) return wd;
        mask = (64'd1 << (8 * size)) - 1;
        return 32'((longint'(word) & ~(mask << sh)) | ((longint'(wd) & mask) << sh));
    endfunction

    task automatic bd_write(input int unsigned idx, input logic [31:0] d);
        bd_addr = MEM_AW'(idx);
        bd_data = d;
        bd_we   = 1'b1;
        @(posedge clk); #1;
        bd_we = 1'b0;
        ref_mem[idx] = d;
    endtask

    // Offer one request in the current (ready) cycle; record activity until req_ready returns
    task automatic run_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                           input logic [4:0] r, input bit fl);
        mem_op = op; addr = a; wdata = wd; rd = r; flush = 1'b0; req_valid = 1'b1;
        rd_cyc = -1; wr_cyc = -1; rd_cnt = 0; wr_cnt = 0; wreq_cnt = 0; wreq_cyc = -1;
        fault_cyc = -1; ready_cyc = -1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush     = fl;
        for (int c = 1; c <= 10; c++) begin
            if (mem_en && !mem_we) begin
                rd_cnt++;
                if (rd_cyc < 0) begin rd_cyc = c; rd_addr_seen = mem_addr; end
            end
            if (mem_en && mem_we) begin
                wr_cnt++;
                if (wr_cyc < 0) begin wr_cyc = c; wr_addr_seen = mem_addr; wr_word = mem_wdata; end
            end
            if (write_req) begin
                wreq_cnt++; wreq_cyc = c; wreq_addr = write_addr; wreq_data = write_data;
            end
            if (fault) begin fault_cyc = c; fcode_seen = fault_code; end
            if (req_ready) begin ready_cyc = c; break; end
            @(posedge clk); #1;
        end
        flush = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if ({mem_en, mem_we, write_req, fault} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {mem_en, mem_we, write_req, fault}); end
        checks++; if (fault_code !== 2'b00) begin errors++; $display("FAIL reset_fault_code: got %b want 00", fault_code); end
        checks++; if ({write_addr, write_data, mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL reset_fields: got %h %h %h %h want 0", write_addr, write_data, mem_addr, mem_wdata); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if ({req_ready, mem_en} !== 2'b10) begin errors++; $display("FAIL post_reset_idle: got %b want 10", {req_ready, mem_en}); end
    endtask

    task automatic test_loads();
        logic [3:0]  ops [6];
        logic [31:0] as  [6];
        logic [31:0] ex  [6];
        logic [4:0]  r;
        ops = '{4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010};
        as  = '{32'h1, 32'h0, 32'h0, 32'h2, 32'h2, 32'h0};
        ex  = '{32'h0000_0012, 32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8000, 32'h0000_8000, 32'h8000_12F0};
        bd_write(0, 32'h8000_12F0);
        for (int i = 0; i < 6; i++) begin
            r = (i == 0) ? 5'd5 : 5'(i + 6);
            run_req(ops[i], as[i], 32'h0, r, 1'b0);
            checks++; if (rd_cyc !== 1 || rd_addr_seen !== '0) begin errors++; $display("FAIL load%0d_read: cyc %0d addr %h want 1 0", i, rd_cyc, rd_addr_seen); end
            checks++; if (wreq_cyc !== 3 || wreq_cnt !== 1 || ready_cyc !== 3) begin errors++; $display("FAIL load%0d_timing: wreq %0d x%0d ready %0d want 3 x1 3", i, wreq_cyc, wreq_cnt, ready_cyc); end
            checks++; if (wreq_addr !== r) begin errors++; $display("FAIL load%0d_waddr: got %0d want %0d", i, wreq_addr, r); end
            checks++; if (wreq_data !== ex[i]) begin errors++; $display("FAIL load%0d_data: got %h want %h", i, wreq_data, ex[i]); end
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++; if (write_req !== 1'b0) begin errors++; $display("FAIL lw_single_pulse: write_req %b want 0", write_req); end
        end
    endtask

    task automatic test_sb_rmw();
        bd_write(1, 32'h1122_3344);
        run_req(4'b1000, 32'h6, 32'h0000_00AB, 5'd9, 1'b0);
        checks++; if (rd_cyc !== 1 || wr_cyc !== 3 || ready_cyc !== 4) begin errors++; $display("FAIL sb_timing: rd %0d wr %0d ready %0d want 1 3 4", rd_cyc, wr_cyc, ready_cyc); end
        checks++; if (wr_word !== 32'h11AB_3344 || wr_addr_seen !== MEM_AW'(1)) begin errors++; $display("FAIL sb_word: got %h @%0d want 11ab3344 @1", wr_word, wr_addr_seen); end
        checks++; if (wreq_cnt !== 0) begin errors++; $display("FAIL sb_no_wb: got %0d want 0", wreq_cnt); end
        ref_mem[1] = 32'h11AB_3344;
        run_req(4'b0010, 32'h4, 32'h0, 5'd7, 1'b0);
        checks++; if (wreq_data !== 32'h11AB_3344) begin errors++; $display("FAIL sb_readback: got %h want 11ab3344", wreq_data); end
    endtask

    task automatic test_faults();
        logic [3:0]  ops [3];
        logic [31:0] as  [3];
        logic [1:0]  cs  [3];
        ops = '{4'b1010, 4'b0011, 4'b0010};
        as  = '{32'h3, 32'h0, 32'h200};
        cs  = '{2'b01, 2'b11, 2'b10};
        for (int i = 0; i < 3; i++) begin
            run_req(ops[i], as[i], 32'hDEAD_BEEF, 5'd1, 1'b0);
            checks++; if (fault_cyc !== 1 || fcode_seen !== cs[i]) begin errors++; $display("FAIL fault%0d: cyc %0d code %b want 1 %b", i, fault_cyc, fcode_seen, cs[i]); end
            checks++; if (rd_cnt + wr_cnt !== 0 || ready_cyc !== 1) begin errors++; $display("FAIL fault%0d_noaccess: mem %0d ready %0d want 0 1", i, rd_cnt + wr_cnt, ready_cyc); end
        end
        @(posedge clk); #1;
        checks++; if (fault !== 1'b0 || fault_code !== 2'b10) begin errors++; $display("FAIL fault_hold: fault %b code %b want 0 10", fault, fault_code); end
    endtask

    task automatic test_flush();
        logic [31:0] exp_w;
        mem_op = 4'b0010; addr = 32'h0; rd = 5'd3; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        checks++; if ({req_ready, mem_en, fault} !== 3'b100) begin errors++; $display("FAIL flush_drop: got %b want 100", {req_ready, mem_en, fault}); end
        @(posedge clk); #1;
        checks++; if ({mem_en, write_req} !== 2'b00) begin errors++; $display("FAIL flush_quiet: got %b want 00", {mem_en, write_req}); end
        exp_w = model_store(ref_mem[2], 4'b1001, 32'hA, 32'h1234_BEEF);
        run_req(4'b1001, 32'hA, 32'h1234_BEEF, 5'd0, 1'b1);
        checks++; if (wr_cyc !== 3 || wr_word !== exp_w || ready_cyc !== 4) begin errors++; $display("FAIL flush_sh: wr %0d word %h ready %0d want 3 %h 4", wr_cyc, wr_word, ready_cyc, exp_w); end
        ref_mem[2] = exp_w;
    endtask

    task automatic test_reset_mid();
        int unsigned s;
        bd_write(9, 32'hCAFE_F00D);
        mem_op = 4'b1000; addr = 32'h25; wdata = 32'h77; rd = 5'd0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        s = wr_strobes;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if ({req_ready, mem_en, mem_we} !== 3'b100) begin errors++; $display("FAIL reset_mid_idle: got %b want 100", {req_ready, mem_en, mem_we}); end
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (wr_strobes !== s || ram[9] !== 32'hCAFE_F00D) begin errors++; $display("FAIL reset_mid_ram: strobes %0d word %h want %0d cafef00d", wr_strobes, ram[9], s); end
        run_req(4'b0010, 32'hC, 32'h0, 5'd0, 1'b0);
        checks++; if (rd_cyc !== 1 || wreq_cnt !== 0 || ready_cyc !== 3) begin errors++; $display("FAIL lw_rd0: rd %0d wreq %0d ready %0d want 1 0 3", rd_cyc, wreq_cnt, ready_cyc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        d = $urandom;
        run_req(4'b1010, 32'h20, d, 5'd0, 1'b0);
        checks++; if (wr_cyc !== 1 || ready_cyc !== 2 || wr_word !== d) begin errors++; $display("FAIL b2b_sw: wr %0d ready %0d word %h want 1 2 %h", wr_cyc, ready_cyc, wr_word, d); end
        ref_mem[8] = d;
        run_req(4'b0010, 32'h20, 32'h0, 5'd3, 1'b0);
        checks++; if (rd_cyc !== 1 || wreq_data !== d) begin errors++; $display("FAIL b2b_lw: rd %0d data %h want 1 %h", rd_cyc, wreq_data, d); end
        run_req(4'b0100, 32'h23, 32'h0, 5'd4, 1'b0);
        checks++; if (rd_cyc !== 1 || wreq_data !== model_load(d, 4'b0100, 32'h23)) begin errors++; $display("FAIL b2b_lbu: rd %0d data %h want 1 %h", rd_cyc, wreq_data, model_load(d, 4'b0100, 32'h23)); end
    endtask

    task automatic test_random();
        logic [3:0]  legal_ops [8];
        logic [3:0]  op;
        logic [31:0] a, wd, exp_d;
        logic [4:0]  r;
        logic [1:0]  code;
        int          idx, exp_ready, exp_rd, exp_wr, exp_wreq;
        legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010};
        for (int n = 0; n < 150; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 7)];
            a  = ($urandom_range(0, 11) == 0) ? 32'($urandom) : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 2) != 0) a = a & ~32'(op_size(op) - 1);
            wd = $urandom;
            r  = 5'($urandom);
            code = model_code(op, a);
            idx  = int'(a / 4);
            exp_rd = -1; exp_wr = -1; exp_wreq = 0; exp_d = 32'h0;
            if (code != 2'd0) exp_ready = 1;
            else if (op[3] && op_size(op) == 4) begin exp_wr = 1; exp_ready = 2; exp_d = wd; end
            else if (op[3]) begin exp_rd = 1; exp_wr = 3; exp_ready = 4; exp_d = model_store(ref_mem[idx], op, a, wd); end
            else begin exp_rd = 1; exp_ready = 3; exp_wreq = (r != 5'd0) ? 1 : 0; exp_d = model_load(ref_mem[idx], op, a); end
            run_req(op, a, wd, r, 1'($urandom_range(0, 1)));
            checks++; if (ready_cyc !== exp_ready) begin errors++; $display("FAIL rnd%0d_ready: op %b a %h got %0d want %0d", n, op, a, ready_cyc, exp_ready); end
            checks++; if ((fault_cyc === 1) !== (code != 2'd0) || (code != 2'd0 && fcode_seen !== code)) begin errors++; $display("FAIL rnd%0d_fault: op %b a %h cyc %0d code %b want %b", n, op, a, fault_cyc, fcode_seen, code); end
            checks++; if (rd_cyc !== exp_rd || wr_cyc !== exp_wr || rd_cnt + wr_cnt !== int'(exp_rd > 0) + int'(exp_wr > 0)) begin errors++; $display("FAIL rnd%0d_mem: rd %0d wr %0d want %0d %0d", n, rd_cyc, wr_cyc, exp_rd, exp_wr); end
            checks++; if (wreq_cnt !== exp_wreq) begin errors++; $display("FAIL rnd%0d_wreq: got %0d want %0d", n, wreq_cnt, exp_wreq); end
            if (exp_wreq == 1) begin
                checks++; if (wreq_data !== exp_d || wreq_addr !== r) begin errors++; $display("FAIL rnd%0d_load: op %b a %h got %h->%0d want %h->%0d", n, op, a, wreq_data, wreq_addr, exp_d, r); end
            end
            if (exp_wr > 0) begin
                checks++; if (wr_word !== exp_d || wr_addr_seen !== MEM_AW'(idx)) begin errors++; $display("FAIL rnd%0d_store: op %b a %h got %h@%0d want %h@%0d", n, op, a, wr_word, wr_addr_seen, exp_d, idx); end
                ref_mem[idx] = exp_d;
            end
        end
        repeat (2) @(posedge clk); #1;
        begin
            int bad = 0;
            for (int i = 0; i < int'(DEPTH); i++) if (ram[i] !== ref_mem[i]) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL ram_image: %0d words differ, want 0", bad); end
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; flush = 1'b0;
        mem_op = 4'b0; addr = 32'h0; wdata = 32'h0; rd = 5'd0;
        for (int i = 0; i < int'(DEPTH); i++) bd_write(i, $urandom);
        test_reset();
        test_loads();
        test_sb_rmw();
        test_faults();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
